// File: rtl/updown_tick_counter_pkg.sv
// Shared definitions for the up/down tick counter: FSM state encoding,
// count-direction encoding and the clock-to-tick divide ratio.
package upcnt_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int div_ratio(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/updown_tick_counter_tick_gen.sv
// Clock-enable generator: one-cycle o_tick every CLK_HZ/TICK_HZ clocks while enabled.
// Tick is combinational from the divider register; no backpressure, restart zeroes the phase.
module tick_gen
  import upcnt_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  localparam int DIV = div_ratio(CLK_HZ, TICK_HZ);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // Disabled or restarted dividers go back to zero, so a pause discards the partial period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (i_restart || !i_en || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign o_tick = i_en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/updown_tick_counter.sv
// Run/stop modulo-MODULUS up/down counter advanced by an internal tick; optional lap
// register under `LAP_CAPTURE_EN. Count updates one clock after a tick; no backpressure.
module updown_tick_counter
  import upcnt_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int MODULUS = 10_000,
  parameter int CW      = $clog2(MODULUS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_clr,
  input  logic          i_dir,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_lap,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_lap,
  output logic          o_wrap,
  output logic          o_running
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MODULUS - 1);
  localparam logic [CW:0]   MOD_EXT = (CW + 1)'(MODULUS);

  state_t        state;
  logic          tick;
  logic          run_now;
  logic          start_ok;
  logic          load_big;
  logic [CW-1:0] load_clamped;

  assign run_now      = (state == ST_RUN);
  assign start_ok     = (state == ST_STOP) && i_start && !i_stop;
  assign load_big     = ({1'b0, i_load_val} >= MOD_EXT);
  assign load_clamped = load_big ? CNT_MAX : i_load_val;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .i_en      (run_now),
    .i_restart (start_ok),
    .o_tick    (tick)
  );

  // Stop dominates start so a simultaneous pair never leaves the counter running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_STOP;
      o_running <= 1'b0;
    end else begin
      case (state)
        ST_STOP: begin
          if (i_start && !i_stop) begin
            state     <= ST_RUN;
            o_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            state     <= ST_STOP;
            o_running <= 1'b0;
          end
        end
        default: begin
          state     <= ST_STOP;
          o_running <= 1'b0;
        end
      endcase
    end
  end

  // Uses the current state, so a tick coinciding with i_stop still advances the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_count <= '0;
      o_wrap  <= 1'b0;
    end else begin
      o_wrap <= 1'b0;
      if (run_now) begin
        if (tick) begin
          if (i_dir == DIR_DOWN) begin
            if (o_count == '0) begin
              o_count <= CNT_MAX;
              o_wrap  <= 1'b1;
            end else begin
              o_count <= o_count - CW'(1);
            end
          end else begin
            if (o_count == CNT_MAX) begin
              o_count <= '0;
              o_wrap  <= 1'b1;
            end else begin
              o_count <= o_count + CW'(1);
            end
          end
        end
      end else if (i_clr) begin
        o_count <= '0;
      end else if (i_load) begin
        o_count <= load_clamped;
      end
    end
  end

`ifdef LAP_CAPTURE_EN
  // Captures the pre-tick count; clear in STOP wipes the lap as well.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_lap <= '0;
    end else if (!run_now && i_clr) begin
      o_lap <= '0;
    end else if (i_lap) begin
      o_lap <= o_count;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = i_lap;
  assign o_lap      = '0;
`endif

endmodule
